// File: rtl/wimax_frame_ctrl.sv
// Frame sequencer for the PRBS -> FEC -> interleaver -> modulator transmit chain.
// Reseeds the randomizer per block, forwards BLOCK_BITS bits per block, then waits for all symbols.
module wimax_frame_ctrl #(
  parameter int unsigned BLOCK_BITS     = 96,
  parameter int unsigned SYMS_PER_BLOCK = 96,
  parameter int unsigned TIMEOUT        = 1023,
  parameter int unsigned NB_W           = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            start,
  input  logic [NB_W-1:0] num_blocks,
  input  logic            src_valid,
  input  logic            src_data,
  output logic            src_ready,
  output logic            prbs_load,
  output logic            prbs_enable,
  output logic            prbs_in_valid,
  output logic            prbs_in_data,
  input  logic            pipe_ready,
  input  logic            sym_valid,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [NB_W-1:0] block_cnt
);

  localparam int unsigned BIT_W = $clog2(BLOCK_BITS);
  localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DRAIN} state_t;

  state_t          r_state, w_state_nxt;
  logic [NB_W-1:0] r_nb, r_blk;
  logic [BIT_W-1:0] r_bits;
  logic [15:0]     r_syms, w_syms_nxt, w_sym_target;
  logic [TO_W-1:0] r_to, w_to_nxt;
  logic            r_done, r_error;
  logic            w_xfer, w_last_bit, w_accept, w_bad_start, w_complete, w_timeout;

  assign w_sym_target = 16'(r_nb) * 16'(SYMS_PER_BLOCK);

  // Symbols from early blocks arrive while later blocks still stream, so count in every busy state.
  always_comb begin
    w_syms_nxt = r_syms;
    if ((r_state != S_IDLE) && sym_valid && (r_syms != w_sym_target))
      w_syms_nxt = r_syms + 16'd1;
    w_to_nxt = r_to;
    if (sym_valid)
      w_to_nxt = '0;
    else if (r_state == S_DRAIN)
      w_to_nxt = r_to + 1'b1;
  end

  always_comb begin
    w_state_nxt   = r_state;
    src_ready     = 1'b0;
    prbs_load     = 1'b0;
    prbs_enable   = 1'b0;
    prbs_in_valid = 1'b0;
    prbs_in_data  = 1'b0;
    w_xfer        = 1'b0;
    w_last_bit    = 1'b0;
    w_accept      = 1'b0;
    w_bad_start   = 1'b0;
    w_complete    = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accept    = start && (num_blocks != '0);
        w_bad_start = start && (num_blocks == '0);
        if (w_accept)
          w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        prbs_load   = 1'b1;
        prbs_enable = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        prbs_enable   = 1'b1;
        src_ready     = pipe_ready;
        prbs_in_valid = src_valid;
        prbs_in_data  = src_data;
        w_xfer        = src_valid & pipe_ready;
        w_last_bit    = w_xfer && (r_bits == BIT_W'(BLOCK_BITS - 1));
        if (w_last_bit)
          w_state_nxt = ((r_blk + 1'b1) == r_nb) ? S_DRAIN : S_LOAD;
      end
      S_DRAIN: begin
        prbs_enable = 1'b1;
        // Completion takes priority over a coincident timeout.
        w_complete  = (w_syms_nxt == w_sym_target);
        w_timeout   = !w_complete && (w_to_nxt == TO_W'(TIMEOUT));
        if (w_complete || w_timeout)
          w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_nb    <= '0;
      r_blk   <= '0;
      r_bits  <= '0;
      r_syms  <= '0;
      r_to    <= '0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_complete;
      r_error <= w_bad_start | w_timeout;
      r_syms  <= w_syms_nxt;
      r_to    <= w_to_nxt;
      if (w_accept) begin
        r_nb   <= num_blocks;
        r_blk  <= '0;
        r_bits <= '0;
        r_syms <= '0;
        r_to   <= '0;
      end else if (w_xfer) begin
        if (w_last_bit) begin
          r_bits <= '0;
          r_blk  <= r_blk + 1'b1;
        end else begin
          r_bits <= r_bits + 1'b1;
        end
      end
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign error     = r_error;
  assign block_cnt = r_blk;

endmodule
